// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : ID-side, forwarding-source and EX-side signal bundle for id_ex_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [3:0]        id_alufn;
  logic              id_asel;
  logic              id_bsel;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_rd;
  logic [XLEN-1:0]   exm_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              stall;
  logic              flush;
  logic              hazard_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [4:0]        ex_shamt;
  logic [3:0]        ex_alufn;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alufn, id_asel, id_bsel, id_reg_write, id_mem_read, id_mem_write,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
           stall, flush,
    input  hazard_stall, ex_valid, ex_a, ex_b, ex_shamt, ex_alufn, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alufn, id_asel, id_bsel, id_reg_write, id_mem_read, id_mem_write,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
           stall, flush,
    output hazard_stall, ex_valid, ex_a, ex_b, ex_shamt, ex_alufn, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with operand select, forwarding and
//            load-use bubble insertion. Macro IDEX_FWD_EN enables forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        alufn_q, alufn_d;
  logic              asel_q, asel_d;
  logic              bsel_q, bsel_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic              hazard;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] s1,
                                    input logic [REG_AW-1:0] s2);
    return (rd != '0) && ((rd == s1) || (rd == s2));
  endfunction

  logic load_use;
  assign load_use = valid_q & mem_read_q & bus.id_valid & id_reads(rd_q, bus.id_rs1, bus.id_rs2);

`ifdef IDEX_FWD_EN
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] src,
                                          input logic [XLEN-1:0]   rf);
    if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == src))
      return bus.exm_result;
    else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == src))
      return bus.wb_result;
    else
      return rf;
  endfunction

  assign fwd_rs1 = fwd(rs1_q, rs1_data_q);
  assign fwd_rs2 = fwd(rs2_q, rs2_data_q);
  assign hazard  = load_use;
`else
  // Without bypassing, any in-flight writer of an ID source must drain first.
  logic raw_ex, raw_exm;
  assign raw_ex  = valid_q & reg_write_q & bus.id_valid & id_reads(rd_q, bus.id_rs1, bus.id_rs2);
  assign raw_exm = bus.exm_reg_write & bus.id_valid & id_reads(bus.exm_rd, bus.id_rs1, bus.id_rs2);
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;
  assign hazard  = load_use | raw_ex | raw_exm;
`endif

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alufn_d     = alufn_q;
    asel_d      = asel_q;
    bsel_d      = bsel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (bus.flush || (!bus.stall && hazard)) begin
      // Bubble: data registers keep their contents, only validity is killed.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rd_d        = bus.id_rd;
      alufn_d     = bus.id_alufn;
      asel_d      = bus.id_asel;
      bsel_d      = bus.id_bsel;
      reg_write_d = bus.id_reg_write & bus.id_valid;
      mem_read_d  = bus.id_mem_read  & bus.id_valid;
      mem_write_d = bus.id_mem_write & bus.id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alufn_q     <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alufn_q     <= alufn_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_a          = asel_q ? pc_q : fwd_rs1;
  assign bus.ex_b          = bsel_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_shamt      = imm_q[4:0];
  assign bus.ex_alufn      = alufn_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q & valid_q;
  assign bus.ex_mem_read   = mem_read_q  & valid_q;
  assign bus.ex_mem_write  = mem_write_q & valid_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed vector table plus hand sequences for id_ex_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();
  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef IDEX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alufn;
    logic        asel, bsel, rw, mr, mw, stall, flush;
    logic        chk_data;
    logic        e_hz, e_valid;
    logic [31:0] e_a, e_b, e_store, e_pc;
    logic [4:0]  e_shamt, e_rd;
    logic [3:0]  e_alufn;
    logic        e_rw, e_mr, e_mw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                          input logic [3:0] fn, input logic as, input logic bs,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid = v;      bus.id_pc = pc;        bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;  bus.id_imm = imm;      bus.id_rs1 = s1;
    bus.id_rs2 = s2;       bus.id_rd = rd;        bus.id_alufn = fn;
    bus.id_asel = as;      bus.id_bsel = bs;      bus.id_reg_write = rw;
    bus.id_mem_read = mr;  bus.id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    bus.exm_reg_write = erw; bus.exm_rd = erd; bus.exm_result = eres;
    bus.wb_reg_write  = wrw; bus.wb_rd  = wrd; bus.wb_result  = wres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1,32'h100,32'h11,32'h22,32'h7,1,2,10,4'h0,0,0,1,0,0,0,0, 1,
                0,1,32'h11,32'h22,32'h22,32'h100,5'd7,10,4'h0,1,0,0};
    vecs[1] = '{1,32'h104,32'h33,32'h44,32'hFFFFFFF0,3,4,11,4'h2,1,1,1,1,0,0,0, 1,
                0,1,32'h104,32'hFFFFFFF0,32'h44,32'h104,5'h10,11,4'h2,1,1,0};
    vecs[2] = '{0,32'h108,32'h55,32'h66,32'h3,5,6,12,4'h3,0,0,1,0,1,0,0, 1,
                0,0,32'h55,32'h66,32'h66,32'h108,5'd3,12,4'h3,0,0,0};
    vecs[3] = '{1,32'h10C,32'h99,32'hAA,32'h7,8,9,12,4'h9,0,1,1,0,0,0,0, 1,
                0,1,32'h99,32'h7,32'hAA,32'h10C,5'd7,12,4'h9,1,0,0};
    vecs[4] = '{1,32'h200,32'h1,32'h2,32'h3,13,14,15,4'h4,1,0,1,1,1,1,0, 1,
                0,1,32'h99,32'h7,32'hAA,32'h10C,5'd7,12,4'h9,1,0,0};
    vecs[5] = '{1,32'h300,32'h4,32'h5,32'h6,15,16,17,4'h5,0,0,1,1,1,1,1, 0,
                0,0,0,0,0,0,0,0,4'h0,0,0,0};
    vecs[6] = '{1,32'h400,32'h1000,32'hDEAD,32'h8,18,19,0,4'h0,0,1,0,0,1,0,0, 1,
                0,1,32'h1000,32'h8,32'hDEAD,32'h400,5'd8,0,4'h0,0,0,1};
    vecs[7] = '{1,32'h500,32'h0,32'h0,32'h1F,0,0,20,4'hF,1,0,1,0,0,0,0, 1,
                0,1,32'h500,32'h0,32'h0,32'h500,5'h1F,20,4'hF,1,0,0};

    drive_id(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    set_fwd(0,0,0,0,0,0);
    bus.stall = 0;
    bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_alufn", 32'(bus.ex_alufn), 0);
    chk("rst_a", bus.ex_a, 0);
    chk("rst_b", bus.ex_b, 0);
    chk("rst_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_id(vecs[i].valid, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm,
               vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].alufn, vecs[i].asel,
               vecs[i].bsel, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      bus.stall = vecs[i].stall;
      bus.flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_hz", i), 32'(bus.hazard_stall), 32'(vecs[i].e_hz));
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_ctrl", i), {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
          {29'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_a", i), bus.ex_a, vecs[i].e_a);
        chk($sformatf("v%0d_b", i), bus.ex_b, vecs[i].e_b);
        chk($sformatf("v%0d_store", i), bus.ex_store_data, vecs[i].e_store);
        chk($sformatf("v%0d_pc", i), bus.ex_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_shamt", i), 32'(bus.ex_shamt), 32'(vecs[i].e_shamt));
        chk($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_alufn", i), 32'(bus.ex_alufn), 32'(vecs[i].e_alufn));
      end
    end
    bus.stall = 0;
    bus.flush = 0;

    // Asynchronous reset between edges, then capture right after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 0);
    chk("arst_rw", 32'(bus.ex_reg_write), 0);
    chk("arst_a", bus.ex_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_id(1,32'h580,32'h5A,32'h5B,32'h0,1,2,22,4'h1,0,0,1,0,0);
    step();
    chk("arst_cap_valid", 32'(bus.ex_valid), 1);
    chk("arst_cap_pc", bus.ex_pc, 32'h580);

    // ALU-to-ALU forward on rs1.
    @(negedge clk);
    drive_id(1,32'h600,32'h11,32'h66,32'h0,5,6,21,4'h6,0,0,1,0,0);
    step();
    drive_id(0,32'h0,32'h0,32'h0,32'h0,0,0,0,4'h0,0,0,0,0,0);
    set_fwd(1,5,32'hABCD,0,0,0);
    #1;
    chk("fwd_exm_a", bus.ex_a, FWD ? 32'hABCD : 32'h11);
    set_fwd(1,0,32'hABCD,0,0,0);
    #1;
    chk("fwd_x0_a", bus.ex_a, 32'h11);

    // Stall for three cycles while the EX/MEM result keeps changing.
    @(negedge clk);
    bus.stall = 1;
    drive_id(0,32'h900,32'h1,32'h2,32'h3,1,2,3,4'hC,0,0,1,0,0);
    for (int k = 0; k < 3; k++) begin
      set_fwd(1,5,32'h100 + 32'(k),0,0,0);
      step();
      chk($sformatf("stall%0d_pc", k), bus.ex_pc, 32'h600);
      chk($sformatf("stall%0d_alufn", k), 32'(bus.ex_alufn), 32'h6);
      chk($sformatf("stall%0d_a", k), bus.ex_a, FWD ? (32'h100 + 32'(k)) : 32'h11);
      @(negedge clk);
    end
    bus.stall = 0;

    // Immediate shift whose rs1 is being written by EX/MEM.
    set_fwd(1,9,32'h0,0,0,0);
    drive_id(1,32'h680,32'h0,32'h0,32'h7,9,0,25,4'h9,0,1,1,0,0);
    #1;
    chk("exm_raw_hz", 32'(bus.hazard_stall), FWD ? 32'd0 : 32'd1);

    // Double match: EX/MEM must win over MEM/WB.
    set_fwd(0,0,0,0,0,0);
    drive_id(1,32'h700,32'h10,32'h77,32'h0,1,7,23,4'h0,0,0,1,0,0);
    step();
    drive_id(0,32'h0,32'h0,32'h0,32'h0,0,0,0,4'h0,0,0,0,0,0);
    set_fwd(1,7,32'h1,1,7,32'h2);
    #1;
    chk("dbl_b", bus.ex_b, FWD ? 32'h1 : 32'h77);
    chk("dbl_store", bus.ex_store_data, FWD ? 32'h1 : 32'h77);
    set_fwd(0,7,32'h1,1,7,32'h2);
    #1;
    chk("wb_b", bus.ex_b, FWD ? 32'h2 : 32'h77);
    set_fwd(0,0,0,0,0,0);

    // Load-use: lw x3 then a consumer of x3.
    @(negedge clk);
    drive_id(1,32'h720,32'h0,32'h0,32'h4,1,2,3,4'h0,0,1,1,1,0);
    step();
    @(negedge clk);
    drive_id(1,32'h724,32'h0,32'h0,32'h0,3,4,24,4'h0,0,0,1,0,0);
    #1;
    chk("lu_hz", 32'(bus.hazard_stall), 1);
    step();
    chk("lu_bub_valid", 32'(bus.ex_valid), 0);
    chk("lu_bub_mr", 32'(bus.ex_mem_read), 0);
    chk("lu_hz_clear", 32'(bus.hazard_stall), 0);
    step();
    chk("lu_cap_valid", 32'(bus.ex_valid), 1);
    chk("lu_cap_pc", bus.ex_pc, 32'h724);
    chk("lu_cap_rd", 32'(bus.ex_rd), 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
